// File: rtl/npu_pkg.sv
// npu_pkg: shared dimensions, sequencer state type and operand/result array
// types for the host sequencer and the matrix_multiplier datapath.
package npu_pkg;

    localparam int unsigned M  = 4;   // rows of A and C
    localparam int unsigned K  = 32;  // inner dimension
    localparam int unsigned N  = 4;   // columns of B and C
    localparam int unsigned DW = 8;   // operand width
    localparam int unsigned CW = 16;  // result width

    typedef enum logic [1:0] {
        StLoad,
        StFire,
        StWait,
        StDrain
    } seq_state_t;

    typedef logic [0:M-1][0:K-1][DW-1:0] a_mat_t;
    typedef logic [0:K-1][0:N-1][DW-1:0] b_mat_t;
    typedef logic [0:M-1][0:N-1][CW-1:0] c_mat_t;

    // Index width for an array of n entries (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mm_result_serializer.sv
// mm_result_serializer: captures the full result matrix on 'capture' and
// streams it out row-major over a valid/ready interface.
//
// Ports:
//   clk, rst             clock, async active-high reset
//   capture              load all of 'c' and start streaming from element 0
//   c                    result matrix from the multiplier
//   out_valid/out_ready  output handshake
//   out_data             current result word (held while stalled)
//   out_last             marks the final word of the matrix
//   drained              final word handshaken this cycle
module mm_result_serializer #(
    parameter int unsigned M  = npu_pkg::M,
    parameter int unsigned N  = npu_pkg::N,
    parameter int unsigned CW = npu_pkg::CW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        capture,
    input  logic [0:M-1][0:N-1][CW-1:0] c,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [CW-1:0]               out_data,
    output logic                        out_last,
    output logic                        drained
);

    localparam int unsigned RW  = npu_pkg::idx_w(M);
    localparam int unsigned CLW = npu_pkg::idx_w(N);

    logic [0:M-1][0:N-1][CW-1:0] res_q;
    logic [RW-1:0]               row_q, row_nxt;
    logic [CLW-1:0]              col_q, col_nxt;
    logic                        at_last;

    always_comb begin
        at_last = (row_q == RW'(M - 1)) && (col_q == CLW'(N - 1));
        if (col_q == CLW'(N - 1)) begin
            col_nxt = '0;
            row_nxt = row_q + 1'b1;
        end else begin
            col_nxt = col_q + 1'b1;
            row_nxt = row_q;
        end
    end

    assign drained = out_valid && out_ready && at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (capture) begin
            res_q     <= c;
            row_q     <= '0;
            col_q     <= '0;
            out_valid <= 1'b1;
            out_data  <= c[0][0];
            out_last  <= (M * N == 1);
        end else if (out_valid && out_ready) begin
            if (at_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                row_q     <= '0;
                col_q     <= '0;
            end else begin
                row_q    <= row_nxt;
                col_q    <= col_nxt;
                out_data <= res_q[row_nxt][col_nxt];
                out_last <= (row_nxt == RW'(M - 1)) && (col_nxt == CLW'(N - 1));
            end
        end
    end

endmodule

// File: rtl/mm_host_sequencer.sv
// mm_host_sequencer: unpacks an operand byte stream into the A/B arrays of
// matrix_multiplier, fires one multiply, waits for done (or a timeout), then
// streams the M*N results out.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   in_valid/in_ready, in_data  operand byte stream (A row-major, then B row-major)
//   out_valid/out_ready         result handshake; out_data result word, out_last final word
//   mm_start                    one-cycle start pulse to the multiplier
//   mm_a, mm_b                  operand arrays, held stable while the multiply runs
//   mm_c, mm_done               multiplier results and completion
//   busy                        job in flight (FIRE/WAIT/DRAIN)
//   timeout_err                 sticky; set on timeout, cleared by the next job's first byte
module mm_host_sequencer #(
    parameter int unsigned M       = npu_pkg::M,
    parameter int unsigned K       = npu_pkg::K,
    parameter int unsigned N       = npu_pkg::N,
    parameter int unsigned DW      = npu_pkg::DW,
    parameter int unsigned CW      = npu_pkg::CW,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [DW-1:0]               in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [CW-1:0]               out_data,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic                        mm_start,
    output logic [0:M-1][0:K-1][DW-1:0] mm_a,
    output logic [0:K-1][0:N-1][DW-1:0] mm_b,
    input  logic [0:M-1][0:N-1][CW-1:0] mm_c,
    input  logic                        mm_done,
    output logic                        busy,
    output logic                        timeout_err
);

    import npu_pkg::*;

    localparam int unsigned Total = M * K + K * N;
    localparam int unsigned IdxW  = idx_w(Total);
    localparam int unsigned AR    = idx_w(M);
    localparam int unsigned AC    = idx_w(K);
    localparam int unsigned BR    = idx_w(K);
    localparam int unsigned BC    = idx_w(N);
    localparam int unsigned TW    = idx_w(TIMEOUT);

    seq_state_t      state;
    logic [IdxW-1:0] idx;
    logic [IdxW-1:0] j;
    logic [TW-1:0]   cnt;
    logic            in_a;
    logic [AR-1:0]   a_row;
    logic [AC-1:0]   a_col;
    logic [BR-1:0]   b_row;
    logic [BC-1:0]   b_col;
    logic            capture;
    logic            drained;

    // Byte position -> operand element (both matrices row-major).
    always_comb begin
        in_a  = (idx < IdxW'(M * K));
        j     = idx - IdxW'(M * K);
        a_row = AR'(idx / IdxW'(K));
        a_col = AC'(idx % IdxW'(K));
        b_row = BR'(j / IdxW'(N));
        b_col = BC'(j % IdxW'(N));
    end

    assign in_ready = (state == StLoad);
    assign busy     = (state != StLoad);
    // done is only honoured in WAIT, so a level left over from the previous
    // job cannot be mistaken for completion during FIRE.
    assign capture  = (state == StWait) && mm_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StLoad;
            idx         <= '0;
            cnt         <= '0;
            mm_start    <= 1'b0;
            timeout_err <= 1'b0;
            mm_a        <= '0;
            mm_b        <= '0;
        end else begin
            case (state)
                StLoad: begin
                    if (in_valid) begin
                        if (idx == '0) timeout_err <= 1'b0;
                        if (in_a) mm_a[a_row][a_col] <= in_data;
                        else      mm_b[b_row][b_col] <= in_data;
                        if (idx == IdxW'(Total - 1)) begin
                            idx      <= '0;
                            mm_start <= 1'b1;
                            state    <= StFire;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                StFire: begin
                    mm_start <= 1'b0;
                    cnt      <= '0;
                    state    <= StWait;
                end
                StWait: begin
                    if (mm_done) begin
                        state <= StDrain;
                    end else if (cnt == TW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= StLoad;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StDrain: begin
                    if (drained) state <= StLoad;
                end
                default: state <= StLoad;
            endcase
        end
    end

    mm_result_serializer #(
        .M  (M),
        .N  (N),
        .CW (CW)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .c         (mm_c),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .drained   (drained)
    );

endmodule

// File: tb/tb_mm_host_sequencer.sv
// Directed bench for mm_host_sequencer with a behavioural multiplier model
// (level done held until the next start, optional hang) and a result queue.
module tb_mm_host_sequencer;

    logic                    clk, rst;
    logic                    in_valid, in_ready;
    logic [7:0]              in_data;
    logic                    out_valid, out_last, out_ready;
    logic [15:0]             out_data;
    logic                    mm_start, mm_done, busy, timeout_err;
    logic [0:3][0:31][7:0]   mm_a, gold_a;
    logic [0:31][0:3][7:0]   mm_b, gold_b;
    logic [0:3][0:3][15:0]   mm_c;

    int         n_cmp, n_mis, n_start, drain_r;
    bit         saw_valid, mdl_hang, mdl_busy;
    int         mdl_cnt, acc;
    logic [15:0] exp_q[$];

    mm_host_sequencer #(
        .M(4), .K(32), .N(4), .DW(8), .CW(16), .TIMEOUT(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .mm_start    (mm_start),
        .mm_a        (mm_a),
        .mm_b        (mm_b),
        .mm_c        (mm_c),
        .mm_done     (mm_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: result ready 6 edges after start, done held high
    // until the next start pulse.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mm_done  <= 1'b0;
            mm_c     <= '0;
            mdl_busy <= 1'b0;
            mdl_cnt  <= 0;
        end else if (mm_start) begin
            mm_done  <= 1'b0;
            mdl_busy <= !mdl_hang;
            mdl_cnt  <= 5;
        end else if (mdl_busy) begin
            if (mdl_cnt == 0) begin
                for (int i = 0; i < 4; i++) begin
                    for (int jj = 0; jj < 4; jj++) begin
                        acc = 0;
                        for (int k = 0; k < 32; k++)
                            acc += int'(mm_a[i][k]) * int'(mm_b[k][jj]);
                        mm_c[i][jj] <= acc[15:0];
                    end
                end
                mm_done  <= 1'b1;
                mdl_busy <= 1'b0;
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (mm_start === 1'b1) n_start++;
        if (out_valid === 1'b1) saw_valid = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind 0: golden (A[i][k]=k+1, B[k][j]=k+1); kind 1: A=1, B=2.
    function automatic logic [7:0] byte_of(input int kind, input int i);
        if (kind == 1) return (i < 128) ? 8'd1 : 8'd2;
        return (i < 128) ? 8'((i % 32) + 1) : 8'(((i - 128) / 4) + 1);
    endfunction

    function automatic logic [15:0] result_of(input int kind);
        return (kind == 1) ? 16'd64 : 16'd11440;
    endfunction

    task automatic load(input int kind, input int from, input int to, input bit gaps);
        for (int i = from; i < to; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    step();
                end
            end
            in_valid = 1'b1;
            in_data  = byte_of(kind, i);
            check("in_ready_load", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n, input bit stall);
        int got = 0;
        int budget = 0;
        logic v, l;
        logic [15:0] d, e;
        while (got < n && budget < 3000) begin
            out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            v = out_valid;
            d = out_data;
            l = out_last;
            step();
            if (v && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                check("out_data", d, e);
                check("out_last", l, drain_r == 15);
                drain_r++;
                got++;
            end else if (v) begin
                check("hold_data", out_data, d);
                check("hold_valid", out_valid, 1);
            end
            budget++;
        end
        out_ready = 1'b0;
        check("drain_count", got, n);
    endtask

    // Called at the edge where the last byte was accepted (+1).
    task automatic fire_and_queue(input int kind);
        check("start_after_last", mm_start, 1);
        check("busy_fire", busy, 1);
        check("in_ready_fire", in_ready, 0);
        for (int i = 0; i < 16; i++) exp_q.push_back(result_of(kind));
        step();
        check("start_one_cycle", mm_start, 0);
        drain_r = 0;
    endtask

    task automatic finish_job(input int kind, input bit stall);
        fire_and_queue(kind);
        drain(16, stall);
        check("idle_out_valid", out_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 1);
        check("sb_empty", exp_q.size(), 0);
    endtask

    task automatic run_job(input int kind, input bit gaps, input bit stall);
        load(kind, 0, 256, gaps);
        finish_job(kind, stall);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_mm_start"}, mm_start, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_mm_a"}, mm_a, 0);
        check({tag, "_mm_b"}, mm_b, 0);
    endtask

    initial begin
        n_cmp = 0; n_mis = 0; n_start = 0; drain_r = 0;
        saw_valid = 1'b0; mdl_hang = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 32; k++) begin
                gold_a[i][k] = 8'(k + 1);
                gold_b[k][i] = 8'(k + 1);
            end

        repeat (2) step();
        check_reset("reset");
        rst = 1'b0;
        step();

        // Back-to-back: second job starts while the model's done is still high.
        run_job(1, 0, 0);
        run_job(0, 0, 0);
        check("start_count_b2b", n_start, 2);

        // Input gaps and output stalls on the golden job.
        run_job(0, 1, 1);
        check("mm_a_golden", mm_a, gold_a);
        check("mm_b_golden", mm_b, gold_b);

        // Timeout: WAIT entered one edge after the start edge, flag 16 edges later.
        mdl_hang = 1'b1;
        load(1, 0, 256, 0);
        check("tmo_start", mm_start, 1);
        saw_valid = 1'b0;
        repeat (16) step();
        check("tmo_not_yet", timeout_err, 0);
        step();
        check("tmo_set", timeout_err, 1);
        check("tmo_busy", busy, 0);
        check("tmo_in_ready", in_ready, 1);
        mdl_hang = 1'b0;
        repeat (3) step();
        check("tmo_sticky", timeout_err, 1);
        check("tmo_no_output", saw_valid, 0);
        load(0, 0, 1, 0);
        check("tmo_cleared", timeout_err, 0);
        load(0, 1, 256, 0);
        finish_job(0, 0);

        // Reset after byte 100.
        load(0, 0, 100, 0);
        rst = 1'b1;
        #1;
        check_reset("rst_load");
        step();
        rst = 1'b0;
        run_job(0, 0, 0);

        // Reset during drain at r=5.
        load(0, 0, 256, 0);
        fire_and_queue(0);
        drain(5, 0);
        rst = 1'b1;
        #1;
        check_reset("rst_drain");
        exp_q.delete();
        step();
        rst = 1'b0;
        run_job(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
